// File: rtl/key_command_queue_pkg.sv
// Command codes, mapped ASCII keys and the byte-to-command decoder shared by the
// key command queue and its FIFO.
package key_cmd_pkg;

    localparam logic [3:0] CMD_NONE    = 4'd0;
    localparam logic [3:0] CMD_UP      = 4'd1;
    localparam logic [3:0] CMD_DOWN    = 4'd2;
    localparam logic [3:0] CMD_LEFT    = 4'd3;
    localparam logic [3:0] CMD_RIGHT   = 4'd4;
    localparam logic [3:0] CMD_CONFIRM = 4'd5;
    localparam logic [3:0] CMD_CANCEL  = 4'd6;

    localparam logic [7:0] KEY_W_LO  = 8'h77;
    localparam logic [7:0] KEY_W_UP  = 8'h57;
    localparam logic [7:0] KEY_S_LO  = 8'h73;
    localparam logic [7:0] KEY_S_UP  = 8'h53;
    localparam logic [7:0] KEY_A_LO  = 8'h61;
    localparam logic [7:0] KEY_A_UP  = 8'h41;
    localparam logic [7:0] KEY_D_LO  = 8'h64;
    localparam logic [7:0] KEY_D_UP  = 8'h44;
    localparam logic [7:0] KEY_X_LO  = 8'h78;
    localparam logic [7:0] KEY_X_UP  = 8'h58;
    localparam logic [7:0] KEY_SPACE = 8'h20;
    localparam logic [7:0] KEY_CR    = 8'h0D;
    localparam logic [7:0] KEY_ESC   = 8'h1B;

    // One queue entry is {code, raw byte}
    localparam int ENTRY_W = 12;

    function automatic logic [3:0] decode_key(input logic [7:0] key);
        logic [3:0] code;
        case (key)
            KEY_W_LO, KEY_W_UP:           code = CMD_UP;
            KEY_S_LO, KEY_S_UP:           code = CMD_DOWN;
            KEY_A_LO, KEY_A_UP:           code = CMD_LEFT;
            KEY_D_LO, KEY_D_UP:           code = CMD_RIGHT;
            KEY_SPACE, KEY_CR:            code = CMD_CONFIRM;
            KEY_X_LO, KEY_X_UP, KEY_ESC:  code = CMD_CANCEL;
            default:                      code = CMD_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_command_queue_if.sv
// UART-byte input side and Machine-facing command handshake of the key command queue.
interface key_command_queue_if #(
    parameter int DEPTH = 4
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   cmd_ready;
    logic                   cmd_valid;
    logic [3:0]             cmd_code;
    logic [7:0]             cmd_key;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, cmd_code, cmd_key, level, overflow
    );

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, cmd_code, cmd_key, level, overflow
    );
endinterface

// File: rtl/key_command_queue_cmd_fifo.sv
// Synchronous FIFO with a registered show-ahead head: rdata always holds the
// oldest entry and keeps its last value once the FIFO drains.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr, rdPtrNext;
    logic [LVL_W-1:0] count, countNext;
    logic [WIDTH-1:0] headNext;
    logic             doPush, doPop, headIsNew;

    assign full  = (count == LVL_FULL);
    assign empty = (count == '0);
    assign level = count;

    always_comb begin
        doPop     = pop && !empty;
        doPush    = push && (!full || doPop);
        rdPtrNext = doPop ? rdPtr + PTR_ONE : rdPtr;
        case ({doPush, doPop})
            2'b10:   countNext = count + LVL_ONE;
            2'b01:   countNext = count - LVL_ONE;
            default: countNext = count;
        endcase
        // The entry being written becomes the head when nothing older survives this edge
        headIsNew = doPush && (empty || (count == LVL_ONE && doPop));
        headNext  = headIsNew ? wdata : mem[rdPtrNext];
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            rdPtr <= rdPtrNext;
            count <= countNext;
            if (countNext != '0) begin
                rdata <= headNext;
            end
        end
    end
endmodule

// File: rtl/key_command_queue.sv
// Decodes UART bytes into game commands and queues them for the Machine FSM.
// Optional repeat filter enabled by defining KEY_CMD_REPEAT_FILTER_EN.
module key_command_queue
    import key_cmd_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int HOLDOFF_CYCLES = 10_000_000
) (
    input  logic                clk,
    input  logic                reset,
    key_command_queue_if.slave  bus
);
    logic [3:0]         keyCode;
    logic               recognised, filtered, fifoFull, fifoEmpty;
    logic               pushReq, popReq;
    logic [ENTRY_W-1:0] headEntry;

    assign keyCode    = decode_key(bus.rx_data);
    assign recognised = bus.rx_valid && (keyCode != CMD_NONE);
    assign popReq     = !fifoEmpty && bus.cmd_ready;
    assign pushReq    = recognised && !filtered && (!fifoFull || popReq);

`ifdef KEY_CMD_REPEAT_FILTER_EN
    logic [31:0] holdCnt;
    logic [3:0]  lastCode;

    assign filtered = (keyCode == lastCode) && (holdCnt != 32'd0);

    // Only accepted pushes restart the window; dropped or filtered keys leave it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            holdCnt  <= 32'd0;
            lastCode <= CMD_NONE;
        end else if (pushReq) begin
            holdCnt  <= 32'(HOLDOFF_CYCLES);
            lastCode <= keyCode;
        end else if (holdCnt != 32'd0) begin
            holdCnt  <= holdCnt - 32'd1;
        end
    end
`else
    assign filtered = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.overflow <= 1'b0;
        end else if (recognised && !filtered && fifoFull && !popReq) begin
            bus.overflow <= 1'b1;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pushReq),
        .pop   (popReq),
        .wdata ({keyCode, bus.rx_data}),
        .rdata (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (bus.level)
    );

    assign bus.cmd_valid = !fifoEmpty;
    assign bus.cmd_code  = headEntry[11:8];
    assign bus.cmd_key   = headEntry[7:0];
endmodule

// File: tb/tb_key_command_queue.sv
// Scoreboard bench for key_command_queue: directed scenarios followed by random
// keystrokes, checked against a queue-based reference model.
module tb_key_command_queue;
    localparam int DEPTH = 4;
    localparam int HOLD  = 20;

    typedef struct {
        logic [3:0] code;
        logic [7:0] key;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_command_queue_if #(.DEPTH(DEPTH)) bus();

    key_command_queue #(
        .DEPTH          (DEPTH),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    entry_t     expQ[$];
    entry_t     mdlLast;
    int         mdlLevel = 0;
    bit         mdlOvf = 1'b0;
    int         cyc = 0;
    logic [3:0] fLast = 4'd0;
    int         fTime = -1000;
    bit         monOn = 1'b0;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [3:0] refCode(input logic [7:0] b);
        case (b)
            "w", "W":            return 4'd1;
            "s", "S":            return 4'd2;
            "a", "A":            return 4'd3;
            "d", "D":            return 4'd4;
            8'h20, 8'h0D:        return 4'd5;
            "x", "X", 8'h1B:     return 4'd6;
            default:             return 4'd0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the reference model
    task automatic cycle(input bit rv, input logic [7:0] d, input bit rdy, input bit rst = 1'b0);
        bit         popNow, filt, accept;
        logic [3:0] code;
        bus.rx_valid  = rv;
        bus.rx_data   = d;
        bus.cmd_ready = rdy;
        reset         = rst;
        @(posedge clk);
        if (rst) begin
            expQ.delete();
            mdlLevel = 0;
            mdlOvf   = 1'b0;
            mdlLast  = '{4'd0, 8'd0};
            fLast    = 4'd0;
        end else begin
            popNow = (mdlLevel > 0) && rdy;
            code   = refCode(d);
            filt   = 1'b0;
`ifdef KEY_CMD_REPEAT_FILTER_EN
            filt   = (code == fLast) && (cyc - fTime <= HOLD);
`endif
            accept = 1'b0;
            if (rv && code != 4'd0 && !filt) begin
                if (mdlLevel < DEPTH || popNow) accept = 1'b1;
                else mdlOvf = 1'b1;
            end
            if (popNow) mdlLevel--;
            if (accept) begin
                expQ.push_back('{code, d});
                mdlLevel++;
                mdlLast = '{code, d};
                fLast   = code;
                fTime   = cyc;
            end
        end
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            check("level", int'(bus.level), mdlLevel);
            check("cmd_valid", int'(bus.cmd_valid), int'(mdlLevel != 0));
            check("overflow", int'(bus.overflow), int'(mdlOvf));
            if (bus.cmd_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry code=%0d key=%0h required=none", bus.cmd_code, bus.cmd_key);
                end else begin
                    check("head_code", int'(bus.cmd_code), int'(expQ[0].code));
                    check("head_key", int'(bus.cmd_key), int'(expQ[0].key));
                    if (bus.cmd_ready) void'(expQ.pop_front());
                end
            end else begin
                check("idle_code", int'(bus.cmd_code), int'(mdlLast.code));
                check("idle_key", int'(bus.cmd_key), int'(mdlLast.key));
            end
        end
    end

    logic [7:0] pool [16] = '{"w", "W", "s", "S", "a", "A", "d", "D",
                              8'h20, 8'h0D, "x", "X", 8'h1B, "q", 8'h00, 8'h7F};

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.cmd_ready = 1'b0;
        @(posedge clk);
        #1;
        // rx_valid during reset must be ignored
        cycle(1'b1, "w", 1'b1, 1'b1);
        cycle(1'b1, "w", 1'b1, 1'b1);
        monOn = 1'b1;

        // single key held while the Machine is busy
        cycle(1'b1, 8'h77, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        // unmapped byte then 'A'
        cycle(1'b1, "q", 1'b0);
        cycle(1'b1, 8'h41, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        // fill, overflow, drain
        cycle(1'b1, "a", 1'b0);
        cycle(1'b1, "s", 1'b0);
        cycle(1'b1, "d", 1'b0);
        cycle(1'b1, "w", 1'b0);
        cycle(1'b1, "x", 1'b0);
        repeat (6) cycle(1'b0, 8'h00, 1'b1);

        // push and pop together while full
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, "a", 1'b0);
        cycle(1'b1, "s", 1'b0);
        cycle(1'b1, "d", 1'b0);
        cycle(1'b1, "w", 1'b0);
        cycle(1'b1, 8'h20, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1);

        // push into empty while ready is already high
        cycle(1'b1, 8'h1B, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        // reset with entries queued
        cycle(1'b1, "W", 1'b0);
        cycle(1'b1, "S", 1'b0);
        cycle(1'b1, "D", 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // repeat window
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, "d", 1'b0);
        repeat (9) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, "d", 1'b0);
        repeat (14) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, "d", 1'b0);
        cycle(1'b1, "a", 1'b0);
        repeat (6) cycle(1'b0, 8'h00, 1'b1);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            b = ($urandom_range(3) == 0) ? 8'($urandom) : pool[$urandom_range(15)];
            cycle($urandom_range(1) == 1, b, $urandom_range(9) < 4, $urandom_range(299) == 0);
        end
        repeat (8) cycle(1'b0, 8'h00, 1'b1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
